// File: rtl/prog_seq.sv
// Program sequencer: IDLE/RUN/DONE FSM driving a program counter with absolute (table) and relative jumps.
// Optional executed-cycle counter enabled by macro PROG_SEQ_CYCLE_CNT_EN; otherwise cyc_cnt is tied to 0.
module prog_seq #(
   parameter int D         = 12,
   parameter int LUT_N     = 4,
   parameter int DONE_ADDR = 128
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     req,
   input  logic                     stall,
   input  logic                     absjump_en,
   input  logic                     reljump_en,
   input  logic [$clog2(LUT_N)-1:0] lut_sel,
   input  logic [D-1:0]             rel_off,
   input  logic                     lut_wr_en,
   input  logic [$clog2(LUT_N)-1:0] lut_wr_addr,
   input  logic [D-1:0]             lut_wr_data,
   output logic [D-1:0]             prog_ctr,
   output logic                     busy,
   output logic                     done,
   output logic [15:0]              cyc_cnt
);

   // A terminal address outside the PC range can never match; avoid a truncated compare.
   localparam bit             DONE_REACHABLE = (DONE_ADDR >= 0) &&
                                               (longint'(DONE_ADDR) < (longint'(1) << D));
   localparam logic [D-1:0]   DONE_PC        = D'(DONE_ADDR);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t         state, state_nxt;
   logic [D-1:0]   pc_nxt;
   logic [D-1:0]   lut [LUT_N];
   logic           at_done;

   assign at_done = DONE_REACHABLE && (prog_ctr == DONE_PC);

   always_comb begin
      state_nxt = state;
      pc_nxt    = prog_ctr;
      case (state)
         S_IDLE: begin
            pc_nxt = '0;
            if (req) state_nxt = S_RUN;
         end
         S_RUN: begin
            if (at_done) begin
               state_nxt = S_DONE;
            end else if (!stall) begin
               if (absjump_en)      pc_nxt = lut[lut_sel];
               else if (reljump_en) pc_nxt = prog_ctr + rel_off;
               else                 pc_nxt = prog_ctr + D'(1);
            end
         end
         S_DONE: begin
            if (!req) begin
               state_nxt = S_IDLE;
               pc_nxt    = '0;
            end
         end
         default: begin
            state_nxt = S_IDLE;
            pc_nxt    = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         prog_ctr <= '0;
      end else begin
         state    <= state_nxt;
         prog_ctr <= pc_nxt;
      end
   end

   // Reads above see the pre-edge entry, so a same-cycle write to the selected index loads the old value.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < LUT_N; i++) lut[i] <= '0;
      end else if (lut_wr_en) begin
         lut[lut_wr_addr] <= lut_wr_data;
      end
   end

   assign busy = (state == S_RUN);
   assign done = (state == S_DONE);

`ifdef PROG_SEQ_CYCLE_CNT_EN
   logic [15:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (state == S_IDLE && req) begin
         cnt <= '0;
      end else if (state == S_RUN && (at_done || !stall) && cnt != 16'hFFFF) begin
         cnt <= cnt + 16'd1;
      end
   end

   assign cyc_cnt = cnt;
`else
   assign cyc_cnt = '0;
`endif

endmodule

// File: tb/tb_prog_seq.sv
// Directed self-checking bench for prog_seq: default instance plus a D=4 instance whose DONE_ADDR is out of range.
module tb_prog_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        req, stall, absjump_en, reljump_en, lut_wr_en;
   logic [1:0]  lut_sel, lut_wr_addr;
   logic [11:0] rel_off, lut_wr_data;
   logic [11:0] prog_ctr;
   logic        busy, done;
   logic [15:0] cyc_cnt;

   logic        s_req;
   logic [0:0]  s_lut_sel, s_lut_wr_addr;
   logic [3:0]  s_rel_off, s_lut_wr_data;
   logic [3:0]  s_prog_ctr;
   logic        s_busy, s_done;
   logic [15:0] s_cyc_cnt;

   int tests  = 0;
   int errors = 0;

   always #5 clk = ~clk;

   prog_seq u_dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .stall       (stall),
      .absjump_en  (absjump_en),
      .reljump_en  (reljump_en),
      .lut_sel     (lut_sel),
      .rel_off     (rel_off),
      .lut_wr_en   (lut_wr_en),
      .lut_wr_addr (lut_wr_addr),
      .lut_wr_data (lut_wr_data),
      .prog_ctr    (prog_ctr),
      .busy        (busy),
      .done        (done),
      .cyc_cnt     (cyc_cnt)
   );

   prog_seq #(.D(4), .LUT_N(2), .DONE_ADDR(20)) u_small (
      .clk         (clk),
      .reset       (reset),
      .req         (s_req),
      .stall       (1'b0),
      .absjump_en  (1'b0),
      .reljump_en  (1'b0),
      .lut_sel     (s_lut_sel),
      .rel_off     (s_rel_off),
      .lut_wr_en   (1'b0),
      .lut_wr_addr (s_lut_wr_addr),
      .lut_wr_data (s_lut_wr_data),
      .prog_ctr    (s_prog_ctr),
      .busy        (s_busy),
      .done        (s_done),
      .cyc_cnt     (s_cyc_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int          ep;
      bit          fin;
      int          done_seen;
      logic [15:0] cnt_exp;
`ifdef PROG_SEQ_CYCLE_CNT_EN
      cnt_exp = 16'd129;
`else
      cnt_exp = 16'd0;
`endif
      reset = 1'b0; req = 1'b0; stall = 1'b0; absjump_en = 1'b0; reljump_en = 1'b0;
      lut_sel = '0; rel_off = '0; lut_wr_en = 1'b0; lut_wr_addr = '0; lut_wr_data = '0;
      s_req = 1'b0; s_lut_sel = '0; s_rel_off = '0; s_lut_wr_addr = '0; s_lut_wr_data = '0;
      #1;
      chk("rst_pc", 32'(prog_ctr), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_cnt", 32'(cyc_cnt), 32'd0);
      #12 reset = 1'b1;
      step();
      step();
      chk("idle_after_release", 32'(busy), 32'd0);

      // Full run 0..128 with three stalls
      req = 1'b1;
      step();
      chk("run_entry_busy", 32'(busy), 32'd1);
      chk("run_entry_pc", 32'(prog_ctr), 32'd0);
      chk("run_entry_cnt", 32'(cyc_cnt), 32'd0);
      ep = 0;
      fin = 1'b0;
      for (int c = 0; c < 300 && !fin; c++) begin
         stall = (c == 5 || c == 6 || c == 70);
         step();
         if (ep == 128) begin
            fin = 1'b1;
            chk("done_flag", 32'(done), 32'd1);
            chk("done_busy", 32'(busy), 32'd0);
            chk("done_pc", 32'(prog_ctr), 32'd128);
         end else begin
            if (!stall) ep++;
            chk("run_pc", 32'(prog_ctr), 32'(ep));
         end
      end
      stall = 1'b0;
      if (!fin) chk("run_timeout", 32'd0, 32'd1);
      chk("done_cnt", 32'(cyc_cnt), 32'(cnt_exp));
      reljump_en = 1'b1;
      rel_off = 12'd3;
      step();
      chk("done_hold_flag", 32'(done), 32'd1);
      chk("done_hold_pc", 32'(prog_ctr), 32'd128);
      reljump_en = 1'b0;
      req = 1'b0;
      step();
      chk("back_idle_busy", 32'(busy), 32'd0);
      chk("back_idle_done", 32'(done), 32'd0);
      chk("back_idle_pc", 32'(prog_ctr), 32'd0);

      // Table writes in IDLE; jumps ignored in IDLE
      lut_wr_en = 1'b1; lut_wr_addr = 2'd2; lut_wr_data = 12'h050;
      step();
      lut_wr_addr = 2'd1; lut_wr_data = 12'h011;
      step();
      lut_wr_en = 1'b0;
      absjump_en = 1'b1; lut_sel = 2'd2;
      step();
      chk("idle_ignore_jump_pc", 32'(prog_ctr), 32'd0);
      chk("idle_ignore_jump_busy", 32'(busy), 32'd0);
      absjump_en = 1'b0;

      req = 1'b1;
      step();
      reljump_en = 1'b1; rel_off = 12'd10;
      step();
      chk("rel_to_10", 32'(prog_ctr), 32'd10);
      absjump_en = 1'b1; lut_sel = 2'd2; rel_off = 12'd5;
      step();
      chk("abs_priority", 32'(prog_ctr), 32'h050);
      absjump_en = 1'b0; rel_off = 12'hFC4;
      step();
      chk("rel_neg_to_20", 32'(prog_ctr), 32'd20);
      rel_off = 12'hFFE;
      step();
      chk("rel_minus2", 32'(prog_ctr), 32'd18);
      reljump_en = 1'b0;
      lut_wr_en = 1'b1; lut_wr_addr = 2'd1; lut_wr_data = 12'h0AA;
      absjump_en = 1'b1; lut_sel = 2'd1;
      step();
      chk("wr_same_cycle_old", 32'(prog_ctr), 32'h011);
      lut_wr_en = 1'b0;
      step();
      chk("wr_then_new", 32'(prog_ctr), 32'h0AA);
      stall = 1'b1;
      step();
      chk("stall_hold", 32'(prog_ctr), 32'h0AA);
      chk("stall_busy", 32'(busy), 32'd1);
      stall = 1'b0; absjump_en = 1'b0; reljump_en = 1'b1; rel_off = 12'hF7B;
      step();
      chk("rel_to_37", 32'(prog_ctr), 32'd37);
      reljump_en = 1'b0;

      // Asynchronous reset mid-run
      reset = 1'b0;
      #1;
      chk("async_rst_pc", 32'(prog_ctr), 32'd0);
      chk("async_rst_busy", 32'(busy), 32'd0);
      chk("async_rst_done", 32'(done), 32'd0);
      chk("async_rst_cnt", 32'(cyc_cnt), 32'd0);
      req = 1'b0;
      #2 reset = 1'b1;
      step();
      chk("post_rst_idle", 32'(busy), 32'd0);
      req = 1'b1;
      step();
      chk("post_rst_run", 32'(busy), 32'd1);
      absjump_en = 1'b1; lut_sel = 2'd2;
      step();
      chk("lut_cleared_by_rst", 32'(prog_ctr), 32'd0);
      absjump_en = 1'b0;

      // D=4 instance: PC wraps 15 -> 0 and DONE_ADDR=20 is unreachable
      s_req = 1'b1;
      step();
      chk("small_entry_busy", 32'(s_busy), 32'd1);
      done_seen = 0;
      for (int c = 0; c < 16; c++) begin
         step();
         if (s_done) done_seen++;
      end
      chk("small_wrap_pc", 32'(s_prog_ctr), 32'd0);
      for (int c = 0; c < 24; c++) begin
         step();
         if (s_done) done_seen++;
      end
      chk("small_pc_after_40", 32'(s_prog_ctr), 32'd8);
      chk("small_never_done", 32'(done_seen), 32'd0);
      chk("small_still_busy", 32'(s_busy), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
